conv_window_sched: RTL and testbench
====================================

CONV_WINDOW_SCHED -- requirements
Module: conv_window_sched

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- TAPS, 9, operand taps per 3x3 window.
- VEC, `LENGTH (16), results per write-back vector.
- TIMEOUT, 64, maximum WAIT_RES cycles.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, layer start pulse.
- cfg_out_w, in, 8, output columns.
- cfg_out_h, in, 8, output rows.
- cfg_stride, in, 3, stride value.
- busy, out, 1, layer in progress.
- done, out, 1, one-cycle end-of-layer pulse.
- err, out, 1, sticky error flag.
- rd_req, out, 1, operand fetch request.
- rd_row, out, 11, window origin row, cfg_stride*row.
- rd_col, out, 11, window origin column, cfg_stride*col.
- rd_tap, out, 4, tap index 0..TAPS-1.
- rd_valid, in, 1, operand tap delivered to the PE this cycle.
- pe_conv_en, out, 1, PE conv_en.
- pe_strd_cyc, out, 3, PE strd_cyc, latched cfg_stride.
- pe_out_en, in, 1, PE result-valid pulse.
- wb_valid, out, 1, output vector valid.
- wb_last, out, 1, final (possibly partial) vector.
- wb_ready, in, 1, downstream accepts vector.

Function
REQ-003 FSM states SHALL be IDLE, FETCH, WAIT_RES, WB, DONE.
REQ-004 IDLE: start with cfg_out_w!=0, cfg_out_h!=0 and cfg_stride in 1..4 SHALL do all of: latch cfg; clear row, col, tap, result counters; clear err; go to FETCH next cycle.
REQ-005 IDLE: start with invalid cfg SHALL set err, stay IDLE and raise no done pulse.
REQ-006 start outside IDLE SHALL be ignored.
REQ-007 busy SHALL be 1 in every state except IDLE.
REQ-008 FETCH: rd_req SHALL be 1. Each rd_valid SHALL increment rd_tap. rd_valid with rd_tap==TAPS-1 SHALL reset tap to 0 and go to WAIT_RES.
REQ-009 pe_conv_en SHALL be the registered rd_valid gated by FETCH: exactly one cycle late, exactly TAPS pulses per window.
REQ-010 WAIT_RES: pe_out_en SHALL increment the result count (0..VEC-1). Next state SHALL be WB if the count reaches VEC or the window is last; otherwise the window counters advance and the FSM returns to FETCH.
REQ-011 Window advance SHALL be: col+1; at col==cfg_out_w-1, col=0 and row+1. The last window is row==cfg_out_h-1 and col==cfg_out_w-1.
REQ-012 WAIT_RES timeout: TIMEOUT cycles without pe_out_en SHALL set err and go to DONE with no write-back.
REQ-013 pe_out_en in any state other than WAIT_RES SHALL set err and be otherwise ignored.
REQ-014 WB: wb_valid SHALL hold until wb_valid&&wb_ready. On that handshake the result count clears; the FSM goes to DONE if wb_last, else advances the window and goes to FETCH.
REQ-015 wb_last SHALL be 1 only in WB when the last window's result is included.
REQ-016 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-017 rd_row and rd_col SHALL be full-width products with no truncation; maximum 255*4=1020.

Reset
REQ-018 Asynchronous reset SHALL immediately force: state=IDLE; all counters 0; all outputs 0, including pe_strd_cyc and err. This SHALL also apply mid-layer.
REQ-019 After reset deasserts, the first start SHALL behave as in REQ-004.

Verification
REQ-020 Stimulus: w=2, h=1, stride=1, rd_valid always 1, pe_out_en 3 cycles after each window. Response: 18 pe_conv_en pulses; one WB with wb_last=1; done 1 cycle after handshake; err=0.
REQ-021 Stimulus: w=4, h=5, stride=2. Response: wb_valid with wb_last=0 after the 16th result, wb_last=1 after the 20th; final rd_row=8, rd_col=6.
REQ-022 Stimulus: hold wb_ready=0 for 10 cycles in WB. Response: wb_valid held; no rd_req; counters frozen.
REQ-023 Stimulus: no pe_out_en after a window. Response: err=1 and done after 64 WAIT_RES cycles; busy=0 next cycle.
REQ-024 Stimulus: start with stride=0, or start while busy. Response: err=1 with FSM staying IDLE for stride=0; start ignored while busy.
REQ-025 Stimulus: reset in FETCH at tap 5. Response: all outputs 0 immediately; a new start re-runs from row 0, col 0, tap 0.

Source files
------------

// File: rtl/conv_window_sched.sv
// conv_window_sched: walks the output windows of one conv layer. For each window it
// fetches TAPS operand taps, waits for the PE result, and after every VEC results
// (or the last window) hands one result vector downstream.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, cfg_*        layer start pulse and its width/height/stride configuration
//   busy, done, err     layer in progress, one-cycle end pulse, sticky error flag
//   rd_req/row/col/tap  operand fetch request and window origin/tap address
//   rd_valid            operand tap delivered to the PE this cycle
//   pe_conv_en          PE tap strobe, pe_strd_cyc latched stride, pe_out_en PE result pulse
//   wb_valid/last/ready result vector write-back handshake
module conv_window_sched #(
    parameter int TAPS    = 9,
    parameter int VEC     = 16,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cfg_out_w,
    input  logic [7:0]  cfg_out_h,
    input  logic [2:0]  cfg_stride,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        rd_req,
    output logic [10:0] rd_row,
    output logic [10:0] rd_col,
    output logic [3:0]  rd_tap,
    input  logic        rd_valid,
    output logic        pe_conv_en,
    output logic [2:0]  pe_strd_cyc,
    input  logic        pe_out_en,
    output logic        wb_valid,
    output logic        wb_last,
    input  logic        wb_ready
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_RES, WB, DONE} state_t;

    localparam int CW = $clog2(VEC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_n;
    logic [7:0]    w, h, row, col;
    logic [2:0]    stride;
    logic [3:0]    tap;
    logic [CW-1:0] res;
    logic [TW-1:0] tmo;
    logic          conv_en, err_q;
    logic          cfg_ok, last_win, tap_end, res_full, tmo_end, wrap;

    assign cfg_ok   = cfg_out_w != 8'd0 && cfg_out_h != 8'd0 && cfg_stride != 3'd0 && cfg_stride <= 3'd4;
    assign last_win = row == h - 8'd1 && col == w - 8'd1;
    assign wrap     = col == w - 8'd1;
    assign tap_end  = tap == 4'(TAPS - 1);
    // The result arriving now is the VEC-th one of the current vector.
    assign res_full = res == CW'(VEC - 1);
    assign tmo_end  = tmo == TW'(TIMEOUT - 1);

    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign rd_req      = state == FETCH;
    assign wb_valid    = state == WB;
    // Window counters are not advanced before WB, so the current window is the last one included.
    assign wb_last     = state == WB && last_win;
    assign rd_row      = 11'(stride) * 11'(row);
    assign rd_col      = 11'(stride) * 11'(col);
    assign rd_tap      = tap;
    assign pe_conv_en  = conv_en;
    assign pe_strd_cyc = stride;
    assign err         = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = start && cfg_ok ? FETCH : IDLE;
            FETCH:    state_n = rd_valid && tap_end ? WAIT_RES : FETCH;
            WAIT_RES: state_n = pe_out_en ? (res_full || last_win ? WB : FETCH)
                                          : (tmo_end ? DONE : WAIT_RES);
            WB:       state_n = wb_ready ? (last_win ? DONE : FETCH) : WB;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w       <= '0;
            h       <= '0;
            stride  <= '0;
            row     <= '0;
            col     <= '0;
            tap     <= '0;
            res     <= '0;
            tmo     <= '0;
            conv_en <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            conv_en <= rd_valid && state == FETCH;
            case (state)
                IDLE: if (start) begin
                    if (cfg_ok) begin
                        w      <= cfg_out_w;
                        h      <= cfg_out_h;
                        stride <= cfg_stride;
                        row    <= '0;
                        col    <= '0;
                        tap    <= '0;
                        res    <= '0;
                        err_q  <= 1'b0;
                    end else begin
                        err_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    tmo <= '0;
                    if (rd_valid) tap <= tap_end ? 4'd0 : tap + 4'd1;
                end
                WAIT_RES: if (pe_out_en) begin
                    res <= res + CW'(1);
                    tmo <= '0;
                    if (!(res_full || last_win)) begin
                        col <= wrap ? 8'd0 : col + 8'd1;
                        row <= wrap ? row + 8'd1 : row;
                    end
                end else begin
                    tmo <= tmo + TW'(1);
                    if (tmo_end) err_q <= 1'b1;
                end
                WB: if (wb_ready) begin
                    res <= '0;
                    if (!last_win) begin
                        col <= wrap ? 8'd0 : col + 8'd1;
                        row <= wrap ? row + 8'd1 : row;
                    end
                end
                default: ;
            endcase
            // A stray PE result outside WAIT_RES is flagged and otherwise dropped.
            if (pe_out_en && state != WAIT_RES) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_conv_window_sched.sv
// tb_conv_window_sched: scoreboard bench for conv_window_sched with a small PE model
// that answers every TAPS conv_en pulses with a result three cycles later.
module tb_conv_window_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  cfg_out_w, cfg_out_h;
    logic [2:0]  cfg_stride;
    logic        busy, done, err, rd_req, rd_valid, pe_conv_en, pe_out_en;
    logic        wb_valid, wb_last, wb_ready;
    logic [10:0] rd_row, rd_col;
    logic [3:0]  rd_tap;
    logic [2:0]  pe_strd_cyc;
    logic        pe_pulse = 1'b0, pe_force = 1'b0, pe_auto = 1'b1;

    typedef struct {
        bit is_done;
        bit last;
        int row;
        int col;
        bit err;
        bit after_wb;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   npass = 0, ntot = 0;
    int   cyc = 0, hs_cyc = 0, conv_cnt = 0, ntap = 0, dly = 0;

    assign pe_out_en = pe_pulse | pe_force;

    conv_window_sched dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h), .cfg_stride(cfg_stride),
        .busy(busy), .done(done), .err(err),
        .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col), .rd_tap(rd_tap),
        .rd_valid(rd_valid), .pe_conv_en(pe_conv_en), .pe_strd_cyc(pe_strd_cyc),
        .pe_out_en(pe_out_en), .wb_valid(wb_valid), .wb_last(wb_last), .wb_ready(wb_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    // PE model: one result three cycles after the ninth tap of each window.
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            ntap = 0;
            dly = 0;
            pe_pulse = 1'b0;
        end else begin
            pe_pulse = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0) pe_pulse = pe_auto;
            end
            if (pe_conv_en) begin
                conv_cnt++;
                ntap++;
                if (ntap == 9) begin
                    ntap = 0;
                    dly = 3;
                end
            end
        end
    end

    // Monitor: pops an expectation on every write-back handshake and every done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_valid && wb_ready) begin
                chk("wb_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("wb_kind", 0, e.is_done);
                    chk("wb_last", wb_last, e.last);
                    chk("wb_row", rd_row, e.row);
                    chk("wb_col", rd_col, e.col);
                end
                hs_cyc = cyc;
            end
            if (done) begin
                chk("done_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("done_kind", 1, e.is_done);
                    chk("done_err", err, e.err);
                    if (e.after_wb) chk("done_latency", cyc - hs_cyc, 1);
                end
            end
        end
    end

    task automatic push_wb(bit last, int row, int col);
        q.push_back('{0, last, row, col, 0, 0});
    endtask

    task automatic push_done(bit err_exp, bit after_wb);
        q.push_back('{1, 0, 0, 0, err_exp, after_wb});
    endtask

    task automatic do_start(int w, int h, int s);
        @(posedge clk); #1;
        cfg_out_w = 8'(w);
        cfg_out_h = 8'(h);
        cfg_stride = 3'(s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(string n);
        int k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(n, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, n;
        reset = 1'b1; start = 1'b0; cfg_out_w = 0; cfg_out_h = 0; cfg_stride = 0;
        rd_valid = 1'b1; wb_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_strd", pe_strd_cyc, 0);
        chk("rst_wb_valid", wb_valid, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Two windows, one vector, 18 taps.
        c0 = conv_cnt;
        push_wb(1, 0, 1);
        push_done(0, 1);
        do_start(2, 1, 1);
        wait_idle("a_idle");
        chk("a_conv_pulses", conv_cnt - c0, 18);
        chk("a_err", err, 0);

        // Invalid stride sets err and stays idle.
        do_start(2, 2, 0);
        @(negedge clk);
        chk("e_err", err, 1);
        chk("e_busy", busy, 0);
        @(negedge clk);
        chk("e_busy2", busy, 0);
        chk("e_done", done, 0);

        // Valid start clears err; start while busy is ignored.
        push_wb(1, 0, 1);
        push_done(0, 1);
        do_start(2, 1, 1);
        @(negedge clk);
        chk("e_err_clr", err, 0);
        do_start(3, 1, 4);
        @(negedge clk);
        chk("e_strd_kept", pe_strd_cyc, 1);
        wait_idle("e_idle");

        // Stray PE result in IDLE.
        @(posedge clk); #1 pe_force = 1'b1;
        @(posedge clk); #1 pe_force = 1'b0;
        @(negedge clk);
        chk("stray_err", err, 1);
        chk("stray_busy", busy, 0);

        // 4x5 windows, stride 2: partial vector after 16, last after 20.
        push_wb(0, 6, 6);
        push_wb(1, 8, 6);
        push_done(0, 1);
        do_start(4, 5, 2);
        @(negedge clk);
        chk("b_strd", pe_strd_cyc, 2);
        chk("b_err_clr", err, 0);
        wait_idle("b_idle");

        // Back-pressure in WB.
        wb_ready = 1'b0;
        push_wb(1, 0, 3);
        push_done(0, 1);
        do_start(2, 1, 3);
        n = 0;
        while (!wb_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("c_wb_seen", wb_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("c_hold_valid", wb_valid, 1);
            chk("c_hold_rd_req", rd_req, 0);
            chk("c_hold_col", rd_col, 3);
            chk("c_hold_tap", rd_tap, 0);
            chk("c_hold_conv", pe_conv_en, 0);
        end
        @(posedge clk); #1 wb_ready = 1'b1;
        wait_idle("c_idle");

        // Result timeout.
        pe_auto = 1'b0;
        push_done(1, 0);
        do_start(1, 1, 1);
        n = 0;
        @(negedge clk);
        while (rd_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!done && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("d_wait_cycles", n, 64);
        chk("d_err", err, 1);
        @(negedge clk);
        chk("d_busy", busy, 0);
        pe_auto = 1'b1;

        // Asynchronous reset mid-fetch, then a clean re-run.
        do_start(3, 2, 2);
        n = 0;
        @(negedge clk);
        while (!(rd_req && rd_col == 2 && rd_tap == 5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("f_reached_tap5", rd_tap, 5);
        #2 reset = 1'b1;
        #1;
        chk("f_busy", busy, 0);
        chk("f_rd_req", rd_req, 0);
        chk("f_rd_col", rd_col, 0);
        chk("f_rd_tap", rd_tap, 0);
        chk("f_strd", pe_strd_cyc, 0);
        chk("f_err", err, 0);
        chk("f_wb_valid", wb_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        push_wb(1, 0, 2);
        push_done(0, 1);
        do_start(2, 1, 2);
        @(negedge clk);
        chk("f_rerun_req", rd_req, 1);
        chk("f_rerun_tap", rd_tap, 0);
        chk("f_rerun_row", rd_row, 0);
        chk("f_rerun_col", rd_col, 0);
        wait_idle("f_idle");

        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
